// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
//
// Purpose: bundles the requester-side and transmitter-side signals of the
// round-robin UART transmit arbiter into one interface.
//
// Parameters:
//   NREQ  number of requesters (2..8)
//   BSN   bytes per frame
//
// Signals:
//   req                requester level requests (held until ack)
//   req_data           frame of requester i at [i*BSN*8 +: BSN*8]
//   ack                one-cycle completion/abort pulse to the granted requester
//   busy               arbiter is between START and DONE
//   grant_id           current/last granted requester index
//   uart_send_flag     one-cycle start pulse to the transmitter
//   dataT              latched frame presented to the transmitter
//   uart_send_comlete  completion pulse from the transmitter
//   timeout_err        one-cycle pulse when a frame is aborted
//
// Modports:
//   master  the arbiter itself
//   slave   requesters plus transmitter (the environment around the arbiter)
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
  parameter int NREQ = 4,
  parameter int BSN  = 6
);
  logic [NREQ-1:0]         req;
  logic [NREQ*BSN*8-1:0]   req_data;
  logic [NREQ-1:0]         ack;
  logic                    busy;
  logic [$clog2(NREQ)-1:0] grant_id;
  logic                    uart_send_flag;
  logic [BSN*8-1:0]        dataT;
  logic                    uart_send_comlete;
  logic                    timeout_err;

  modport master (
    input  req,
    input  req_data,
    input  uart_send_comlete,
    output ack,
    output busy,
    output grant_id,
    output uart_send_flag,
    output dataT,
    output timeout_err
  );

  modport slave (
    output req,
    output req_data,
    output uart_send_comlete,
    input  ack,
    input  busy,
    input  grant_id,
    input  uart_send_flag,
    input  dataT,
    input  timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Purpose: round-robin arbiter sharing one uart_send_nbytes transmitter among
// NREQ frame sources. A granted requester's BSN-byte frame is latched, a
// single start pulse is issued, the frame is held until the transmitter
// reports completion, and then the requester is acknowledged for one cycle.
//
// Parameters:
//   NREQ         number of requesters (2..8)
//   BSN          bytes per frame (must match the transmitter's BN)
//   TIMEOUT_CYC  WAIT cycles allowed before abort (timeout build only)
//
// Ports:
//   sys_clk  system clock
//   rst_n    asynchronous active-low reset
//   bus      uart_tx_arbiter_if.master (requests, frame data, ack, busy,
//            grant_id, uart_send_flag, dataT, uart_send_comlete, timeout_err)
//
// Build option:
//   UART_ARB_TIMEOUT_EN  when defined, a WAIT-state watchdog aborts a frame
//                        after TIMEOUT_CYC WAIT cycles without completion and
//                        pulses timeout_err together with ack. When undefined,
//                        WAIT only exits on uart_send_comlete and timeout_err
//                        is tied low.
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NREQ        = 4,
  parameter int BSN         = 6,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  uart_tx_arbiter_if.master bus
);

  localparam int IW = $clog2(NREQ);
  localparam int FW = BSN * 8;

  // Parameter sanity check at elaboration time.
  if (NREQ < 2 || NREQ > 8 || BSN < 1 || TIMEOUT_CYC < 1) begin : g_param_check
    $fatal(1, "uart_tx_arbiter: illegal parameter set");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state_reg,      state_next;
  logic [IW-1:0]   grant_id_reg,   grant_id_next;
  logic [IW-1:0]   last_grant_reg, last_grant_next;
  logic [NREQ-1:0] ack_mask_reg,   ack_mask_next;
  logic [FW-1:0]   data_reg,       data_next;

  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] grant_onehot;
  logic [FW-1:0]   req_slice [NREQ];
  logic [IW-1:0]   cand_idx  [NREQ];
  logic            pick_valid;
  logic [IW-1:0]   pick_idx;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] wait_cnt_reg, wait_cnt_next;
  logic          abort_reg,    abort_next;
  logic          expire;

  // The counter holds the number of WAIT cycles already completed; the frame
  // is abandoned in the cycle where it would reach TIMEOUT_CYC, so WAIT lasts
  // exactly TIMEOUT_CYC cycles when the transmitter never answers.
  assign expire = (wait_cnt_reg == TW'(TIMEOUT_CYC - 1));
`endif

  // A requester whose ack was issued in DONE may still show req high in the
  // following IDLE cycle (its ack is registered on its side); masking it for
  // that one cycle prevents a duplicate grant.
  assign eligible = bus.req & ~ack_mask_reg;

  // Per-requester frame slices, one-hot of the current grant, and the
  // rotated candidate order: candidate k is (last_grant + 1 + k) mod NREQ.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
    logic [IW:0] cand_sum;

    assign req_slice[gi]    = bus.req_data[gi*FW +: FW];
    assign grant_onehot[gi] = (grant_id_reg == IW'(gi));
    assign cand_sum         = {1'b0, last_grant_reg} + (IW+1)'(gi + 1);
    assign cand_idx[gi]     = (cand_sum >= (IW+1)'(NREQ))
                              ? IW'(cand_sum - (IW+1)'(NREQ))
                              : cand_sum[IW-1:0];
  end

  // Scan candidates from farthest to nearest so that the nearest eligible
  // requester after last_grant overwrites any earlier hit.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = last_grant_reg;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (eligible[cand_idx[k]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx[k];
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      grant_id_reg   <= '0;
      last_grant_reg <= IW'(NREQ - 1);
      ack_mask_reg   <= '0;
      data_reg       <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      wait_cnt_reg   <= '0;
      abort_reg      <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      grant_id_reg   <= grant_id_next;
      last_grant_reg <= last_grant_next;
      ack_mask_reg   <= ack_mask_next;
      data_reg       <= data_next;
`ifdef UART_ARB_TIMEOUT_EN
      wait_cnt_reg   <= wait_cnt_next;
      abort_reg      <= abort_next;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_next      = state_reg;
    grant_id_next   = grant_id_reg;
    last_grant_next = last_grant_reg;
    ack_mask_next   = '0;          // only survives the single cycle after DONE
    data_next       = data_reg;    // frame is only ever changed by a grant
`ifdef UART_ARB_TIMEOUT_EN
    wait_cnt_next   = wait_cnt_reg;
    abort_next      = abort_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          grant_id_next = pick_idx;
          data_next     = req_slice[pick_idx];
          state_next    = START;
        end
      end

      START: begin
        state_next = WAIT;
`ifdef UART_ARB_TIMEOUT_EN
        wait_cnt_next = '0;
        abort_next    = 1'b0;
`endif
      end

      WAIT: begin
        // Completion wins over a simultaneous timeout.
        if (bus.uart_send_comlete) begin
          state_next = DONE;
`ifdef UART_ARB_TIMEOUT_EN
        end else if (expire) begin
          state_next = DONE;
          abort_next = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt_reg + TW'(1);
`endif
        end
      end

      DONE: begin
        last_grant_next = grant_id_reg;
        ack_mask_next   = grant_onehot;
        state_next      = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs are decoded from registered state, so an asynchronous reset
  // forces them to their idle values immediately.
  assign bus.ack            = (state_reg == DONE) ? grant_onehot : '0;
  assign bus.busy           = (state_reg != IDLE);
  assign bus.grant_id       = grant_id_reg;
  assign bus.uart_send_flag = (state_reg == START);
  assign bus.dataT          = data_reg;

`ifdef UART_ARB_TIMEOUT_EN
  assign bus.timeout_err = (state_reg == DONE) && abort_reg;
`else
  assign bus.timeout_err = 1'b0;
`endif

endmodule
